// File: rtl/bp_be_fe_cmd_queue.sv
// bp_be_fe_cmd_queue: backend-side FIFO of FE commands.
// Buffers commands from the BE, presents the head to the FE with a valid/yumi
// handshake, and tracks the FE mode from the commands the FE consumes.
// Command layout (MSB..LSB): {operands[branch_metadata_fwd_width_p],
// npc[vaddr_width_p], opcode[3]}. Entries are stored and forwarded unmodified.
module bp_be_fe_cmd_queue #(
    parameter int vaddr_width_p               = 39,
    parameter int branch_metadata_fwd_width_p = 36,
    parameter int els_p                       = 4,
    localparam int fe_cmd_width_lp = branch_metadata_fwd_width_p + vaddr_width_p + 3,
    localparam int count_width_lp  = $clog2(els_p + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [fe_cmd_width_lp-1:0] cmd_i,
    input  logic                       cmd_v_i,
    output logic                       cmd_ready_o,
    output logic [fe_cmd_width_lp-1:0] fe_cmd_o,
    output logic                       fe_cmd_v_o,
    input  logic                       fe_cmd_yumi_i,
    output logic                       attaboy_drop_o,
    output logic                       nonattaboy_pending_o,
    output logic [count_width_lp-1:0]  count_o,
    output logic [1:0]                 fe_mode_o
);

    localparam int ptr_width_lp = $clog2(els_p);

    // Opcode encodings carried in the low three bits of a command
    localparam logic [2:0] e_op_state_reset          = 3'd0;
    localparam logic [2:0] e_op_pc_redirection       = 3'd1;
    localparam logic [2:0] e_op_icache_fill_restart  = 3'd2;
    localparam logic [2:0] e_op_icache_fill_resume   = 3'd3;
    localparam logic [2:0] e_op_icache_fence         = 3'd4;
    localparam logic [2:0] e_op_wait                 = 3'd5;
    localparam logic [2:0] e_op_attaboy              = 3'd6;

    localparam logic [count_width_lp-1:0] full_lp     = count_width_lp'(els_p);
    localparam logic [count_width_lp-1:0] reserve_lp  = count_width_lp'(els_p - 1);
    localparam logic [ptr_width_lp-1:0]   last_ptr_lp = ptr_width_lp'(els_p - 1);

    typedef enum logic [1:0] {
        e_mode_reset = 2'd0,
        e_mode_run   = 2'd1,
        e_mode_wait  = 2'd2
    } fe_mode_e;

    logic [fe_cmd_width_lp-1:0] mem [els_p];
    logic [ptr_width_lp-1:0]    rd_ptr, wr_ptr;
    logic [count_width_lp-1:0]  count, na_count;
    fe_mode_e                   fe_mode;

    logic       in_attaboy, head_attaboy, attaboy_room;
    logic       enq, deq, na_inc, na_dec;
    logic [2:0] head_op;

    // Handshake and acceptance decisions from registered occupancy
    always_comb begin
        in_attaboy           = (cmd_i[2:0] == e_op_attaboy);
        head_op              = mem[rd_ptr][2:0];
        head_attaboy         = (head_op == e_op_attaboy);
        // One slot is always kept free so a redirect can never be starved by attaboys
        attaboy_room         = (count < reserve_lp);
        cmd_ready_o          = ~reset_i & (count < full_lp);
        fe_cmd_v_o           = ~reset_i & (count != '0);
        fe_cmd_o             = mem[rd_ptr];
        enq                  = ~reset_i & cmd_v_i & (in_attaboy ? attaboy_room : cmd_ready_o);
        attaboy_drop_o       = ~reset_i & cmd_v_i & in_attaboy & ~attaboy_room;
        deq                  = fe_cmd_yumi_i & fe_cmd_v_o;
        na_inc               = enq & ~in_attaboy;
        na_dec               = deq & ~head_attaboy;
        nonattaboy_pending_o = (na_count != '0);
        count_o              = count;
        fe_mode_o            = fe_mode;
    end

    // Storage write; contents need no reset because count gates visibility
    always_ff @(posedge clk_i) begin
        if (enq)
            mem[wr_ptr] <= cmd_i;
    end

    // Pointers and occupancy counters
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            na_count <= '0;
        end else begin
            if (enq)
                wr_ptr <= (wr_ptr == last_ptr_lp) ? '0 : wr_ptr + 1'b1;
            if (deq)
                rd_ptr <= (rd_ptr == last_ptr_lp) ? '0 : rd_ptr + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            case ({na_inc, na_dec})
                2'b10:   na_count <= na_count + 1'b1;
                2'b01:   na_count <= na_count - 1'b1;
                default: na_count <= na_count;
            endcase
        end
    end

    // FE mode tracker, advanced by the opcode of each consumed head
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fe_mode <= e_mode_reset;
        end else if (deq) begin
            case (fe_mode)
                e_mode_reset: begin
                    if (head_op == e_op_state_reset)
                        fe_mode <= e_mode_run;
                end
                e_mode_run: begin
                    if (head_op == e_op_wait || head_op == e_op_icache_fence)
                        fe_mode <= e_mode_wait;
                end
                e_mode_wait: begin
                    case (head_op)
                        e_op_pc_redirection,
                        e_op_icache_fill_restart,
                        e_op_icache_fill_resume,
                        e_op_state_reset:  fe_mode <= e_mode_run;
                        default:           fe_mode <= e_mode_wait;
                    endcase
                end
                default: fe_mode <= e_mode_reset;
            endcase
        end
    end

    // The FE may only consume a head that is actually presented
    always_ff @(posedge clk_i) begin
        if (!reset_i && fe_cmd_yumi_i)
            assert (fe_cmd_v_o);
    end

endmodule

// File: tb/tb_bp_be_fe_cmd_queue.sv
// Directed table-driven bench for bp_be_fe_cmd_queue (els_p=4).
// Inputs are driven just after the falling edge and outputs sampled 1ns later,
// so each row's expectations describe state left by the previous rows.
module tb_bp_be_fe_cmd_queue;

    localparam int VW  = 39;
    localparam int BW  = 36;
    localparam int ELS = 4;
    localparam int W   = BW + VW + 3;
    localparam int CW  = $clog2(ELS + 1);

    localparam logic [2:0] OP_SR   = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_FRST = 3'd2;
    localparam logic [2:0] OP_FEN  = 3'd4;
    localparam logic [2:0] OP_WAIT = 3'd5;
    localparam logic [2:0] OP_AB   = 3'd6;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic [W-1:0]  cmd_i = '0;
    logic          cmd_v_i = 1'b0;
    logic          cmd_ready_o;
    logic [W-1:0]  fe_cmd_o;
    logic          fe_cmd_v_o;
    logic          fe_cmd_yumi_i = 1'b0;
    logic          attaboy_drop_o;
    logic          nonattaboy_pending_o;
    logic [CW-1:0] count_o;
    logic [1:0]    fe_mode_o;

    bp_be_fe_cmd_queue #(
        .vaddr_width_p(VW),
        .branch_metadata_fwd_width_p(BW),
        .els_p(ELS)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .cmd_i(cmd_i),
        .cmd_v_i(cmd_v_i),
        .cmd_ready_o(cmd_ready_o),
        .fe_cmd_o(fe_cmd_o),
        .fe_cmd_v_o(fe_cmd_v_o),
        .fe_cmd_yumi_i(fe_cmd_yumi_i),
        .attaboy_drop_o(attaboy_drop_o),
        .nonattaboy_pending_o(nonattaboy_pending_o),
        .count_o(count_o),
        .fe_mode_o(fe_mode_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic         rst;
        logic         v;
        logic [W-1:0] cmd;
        logic         y;
        int           cnt;
        logic         fv;
        logic         rdy;
        logic         drop;
        logic         pend;
        logic [1:0]   mode;
        logic [W-1:0] ecmd;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad = 0;

    function automatic logic [W-1:0] mk(input logic [2:0] op, input logic [VW-1:0] npc,
                                        input logic [BW-1:0] meta);
        return {meta, npc, op};
    endfunction

    task automatic add(input logic rst, input logic v, input logic [W-1:0] cmd, input logic y,
                       input int cnt, input logic fv, input logic rdy, input logic drop,
                       input logic pend, input logic [1:0] mode, input logic [W-1:0] ecmd);
        vec_t r;
        r.rst = rst; r.v = v; r.cmd = cmd; r.y = y;
        r.cnt = cnt; r.fv = fv; r.rdy = rdy; r.drop = drop;
        r.pend = pend; r.mode = mode; r.ecmd = ecmd;
        tbl.push_back(r);
    endtask

    task automatic chk(input string name, input int row, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL row %0d %s: got %h want %h", row, name, act, exp);
        end
    endtask

    task automatic run_row(input vec_t r, input int row);
        @(negedge clk_i);
        reset_i       = r.rst;
        cmd_v_i       = r.v;
        cmd_i         = r.cmd;
        fe_cmd_yumi_i = r.y;
        #1;
        chk("count",   row, W'(count_o), W'(r.cnt));
        chk("fe_v",    row, W'(fe_cmd_v_o), W'(r.fv));
        chk("ready",   row, W'(cmd_ready_o), W'(r.rdy));
        chk("drop",    row, W'(attaboy_drop_o), W'(r.drop));
        chk("pending", row, W'(nonattaboy_pending_o), W'(r.pend));
        chk("mode",    row, W'(fe_mode_o), W'(r.mode));
        if (r.fv)
            chk("fe_cmd", row, fe_cmd_o, r.ecmd);
    endtask

    logic [W-1:0] Z, SR, A, B, C, D, E, F, AB, WT, FR, FE, SR2;

    initial begin
        Z   = '0;
        SR  = mk(OP_SR,   39'h00_8000_0000, 36'h0);
        A   = mk(OP_RD,   39'h00_8000_1000, 36'hA_AAAA_AAAA);
        B   = mk(OP_RD,   39'h7F_FFFF_FFFC, 36'h5_5555_5555);
        C   = mk(OP_RD,   39'h00_0000_0004, 36'h1_2345_6789);
        D   = mk(OP_RD,   39'h12_3456_7890, 36'hF_EDCB_A987);
        E   = mk(OP_RD,   39'h40_0000_0000, 36'h8_0000_0001);
        F   = mk(OP_RD,   39'h00_DEAD_BEEC, 36'h0_0BAD_F00D);
        AB  = mk(OP_AB,   39'h00_0000_0040, 36'h3_C3C3_C3C3);
        WT  = mk(OP_WAIT, 39'h00_0000_0000, 36'h0);
        FR  = mk(OP_FRST, 39'h00_8000_2000, 36'h7_0000_0007);
        FE  = mk(OP_FEN,  39'h00_8000_3000, 36'h0);
        SR2 = mk(OP_SR,   39'h00_9000_0000, 36'h1);

        //  rst v cmd y   cnt fv rdy drop pend mode ecmd
        add(1, 0, Z,  0,  0, 0, 0, 0, 0, 0, Z);   // in reset: not ready, not valid
        add(0, 1, SR, 0,  0, 0, 1, 0, 0, 0, Z);
        add(0, 0, Z,  1,  1, 1, 1, 0, 1, 0, SR);  // visible one cycle later, consumed
        add(0, 0, Z,  0,  0, 0, 1, 0, 0, 1, Z);   // reset -> run
        add(0, 1, A,  0,  0, 0, 1, 0, 0, 1, Z);   // fill with redirects
        add(0, 1, B,  0,  1, 1, 1, 0, 1, 1, A);
        add(0, 1, C,  0,  2, 1, 1, 0, 1, 1, A);
        add(0, 1, D,  0,  3, 1, 1, 0, 1, 1, A);
        add(0, 1, E,  0,  4, 1, 0, 0, 1, 1, A);   // full, E held
        add(0, 1, E,  1,  4, 1, 0, 0, 1, 1, A);   // full + yumi: E still refused
        add(0, 1, E,  0,  3, 1, 1, 0, 1, 1, B);   // E accepted across wrap
        add(0, 0, Z,  1,  4, 1, 0, 0, 1, 1, B);
        add(0, 1, AB, 0,  3, 1, 1, 1, 1, 1, C);   // attaboy at count 3 dropped
        add(0, 1, F,  0,  3, 1, 1, 0, 1, 1, C);   // redirect uses reserved slot
        add(0, 0, Z,  1,  4, 1, 0, 0, 1, 1, C);   // drain in order
        add(0, 0, Z,  1,  3, 1, 1, 0, 1, 1, D);
        add(0, 0, Z,  1,  2, 1, 1, 0, 1, 1, E);
        add(0, 0, Z,  1,  1, 1, 1, 0, 1, 1, F);
        add(0, 0, Z,  0,  0, 0, 1, 0, 0, 1, Z);
        add(0, 1, WT, 0,  0, 0, 1, 0, 0, 1, Z);   // mode sequence
        add(0, 1, AB, 0,  1, 1, 1, 0, 1, 1, WT);
        add(0, 1, FR, 0,  2, 1, 1, 0, 1, 1, WT);
        add(0, 0, Z,  1,  3, 1, 1, 0, 1, 1, WT);
        add(0, 0, Z,  1,  2, 1, 1, 0, 1, 2, AB);  // wait
        add(0, 0, Z,  1,  1, 1, 1, 0, 1, 2, FR);  // attaboy kept wait
        add(0, 0, Z,  0,  0, 0, 1, 0, 0, 1, Z);   // fill_restart -> run
        add(0, 1, A,  0,  0, 0, 1, 0, 0, 1, Z);
        add(0, 1, B,  1,  1, 1, 1, 0, 1, 1, A);   // enq + yumi: count steady
        add(0, 1, AB, 1,  1, 1, 1, 0, 1, 1, B);   // attaboy in, redirect out
        add(0, 0, Z,  0,  1, 1, 1, 0, 0, 1, AB);  // only attaboy queued
        add(0, 1, A,  0,  1, 1, 1, 0, 0, 1, AB);
        add(0, 1, B,  0,  2, 1, 1, 0, 1, 1, AB);
        add(1, 0, Z,  0,  3, 0, 0, 0, 1, 1, Z);   // mid-stream reset
        add(0, 0, Z,  0,  0, 0, 1, 0, 0, 0, Z);
        add(0, 1, A,  0,  0, 0, 1, 0, 0, 0, Z);
        add(0, 0, Z,  1,  1, 1, 1, 0, 1, 0, A);   // redirect in reset mode: stays reset
        add(0, 0, Z,  0,  0, 0, 1, 0, 0, 0, Z);

        // one clean reset cycle so the table starts from known state
        @(negedge clk_i);

        foreach (tbl[i])
            run_row(tbl[i], i);

        // Hand sequence: back-to-back enqueue/yumi through reset -> run -> wait -> run
        begin
            vec_t r;
            r = '{0, 1, SR,  0, 0, 0, 1, 0, 0, 0, Z};   run_row(r, 100);
            r = '{0, 1, FE,  1, 1, 1, 1, 0, 1, 0, SR};  run_row(r, 101);
            r = '{0, 1, SR2, 1, 1, 1, 1, 0, 1, 1, FE};  run_row(r, 102);
            r = '{0, 0, Z,   1, 1, 1, 1, 0, 1, 2, SR2}; run_row(r, 103);
            r = '{0, 0, Z,   0, 0, 0, 1, 0, 0, 1, Z};   run_row(r, 104);
            // a second attaboy at count 3 is also dropped, ready stays up
            r = '{0, 1, A,   0, 0, 0, 1, 0, 0, 1, Z};   run_row(r, 105);
            r = '{0, 1, B,   0, 1, 1, 1, 0, 1, 1, A};   run_row(r, 106);
            r = '{0, 1, C,   0, 2, 1, 1, 0, 1, 1, A};   run_row(r, 107);
            r = '{0, 1, AB,  0, 3, 1, 1, 1, 1, 1, A};   run_row(r, 108);
            r = '{0, 1, AB,  0, 3, 1, 1, 1, 1, 1, A};   run_row(r, 109);
            r = '{0, 0, Z,   1, 3, 1, 1, 0, 1, 1, A};   run_row(r, 110);
            r = '{0, 1, AB,  0, 2, 1, 1, 0, 1, 1, B};   run_row(r, 111);
            r = '{0, 0, Z,   0, 3, 1, 1, 0, 1, 1, B};   run_row(r, 112);
        end

        @(negedge clk_i);
        cmd_v_i = 1'b0;
        fe_cmd_yumi_i = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
